// File: rtl/binary_to_gray_pkg.sv
// Shared helpers for the binary-to-Gray converter block.
package binary_to_gray_pkg;

  localparam int DEFAULT_VEC_W = 4;

  // Upper width bound for the generic helper functions. Callers zero-extend
  // their operands to this width.
  localparam int MAX_W = 64;

  // Reflected-binary conversion, width-generic via zero extension.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Number of set bits in a zero-extended vector.
  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/binary_to_gray_comb.sv
// Combinational binary-to-Gray converter, one XOR cell per bit.
module binary_to_gray_comb
  import binary_to_gray_pkg::*;
#(
  parameter int VEC_W = DEFAULT_VEC_W
) (
  input  logic [VEC_W-1:0] bin,
  output logic [VEC_W-1:0] gray
);

  // The MSB passes straight through.
  assign gray[VEC_W-1] = bin[VEC_W-1];

  // Each lower bit is the XOR with its upper neighbour. VEC_W=1 emits no cells.
  for (genvar k = 0; k < VEC_W-1; k++) begin : g_bit
    assign gray[k] = bin[k+1] ^ bin[k];
  end

endmodule

// File: rtl/binary_to_gray_pipe.sv
// Binary-to-Gray converter with a zero-latency output and a registered,
// valid-qualified output that flags single-bit steps between captured codes.
module binary_to_gray_pipe
  import binary_to_gray_pkg::*;
#(
  parameter int VEC_W = DEFAULT_VEC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [VEC_W-1:0] bin_i,
  input  logic             valid_i,
  output logic [VEC_W-1:0] gray_o,
  output logic [VEC_W-1:0] gray_q_o,
  output logic             valid_q_o,
  output logic             step_o
);

  logic [VEC_W-1:0] gray_c;
  logic [VEC_W-1:0] gray_q;
  logic [VEC_W-1:0] diff;
  logic             vld_q;
  logic             step_q;
  logic             have_prev;
  logic             one_bit;

  // A single converter feeds both the combinational and the registered path.
  binary_to_gray_comb #(.VEC_W(VEC_W)) u_conv (
    .bin  (bin_i),
    .gray (gray_c)
  );

  // gray_q doubles as the previously captured code, so no separate copy is
  // kept. Exactly one differing bit means a legal Gray step.
  assign diff    = gray_c ^ gray_q;
  assign one_bit = (popcount(MAX_W'(diff)) == 1);

  // Capture register, valid flag and step monitor; reset wins over valid_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gray_q    <= '0;
      vld_q     <= 1'b0;
      step_q    <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      vld_q <= valid_i;
      if (valid_i) begin
        gray_q    <= gray_c;
        step_q    <= have_prev & one_bit;
        have_prev <= 1'b1;
      end else begin
        step_q <= 1'b0;
      end
    end
  end

  assign gray_o    = gray_c;
  assign gray_q_o  = gray_q;
  assign valid_q_o = vld_q;
  assign step_o    = step_q;

endmodule

// File: tb/tb_binary_to_gray_pipe.sv
// Directed bench for binary_to_gray_pipe at VEC_W = 4, 1 and 8.
module tb_binary_to_gray_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bin4;
  logic       vld4;
  logic [3:0] gray4, grayq4;
  logic       vldq4, step4;

  logic       bin1, gray1, grayq1, vldq1, step1;
  logic [7:0] bin8, gray8, grayq8;
  logic       vld8, vldq8, step8;

  int total = 0;
  int bad   = 0;

  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  always #5 clk = ~clk;

  binary_to_gray_pipe #(.VEC_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bin_i(bin4), .valid_i(vld4),
    .gray_o(gray4), .gray_q_o(grayq4), .valid_q_o(vldq4), .step_o(step4));

  binary_to_gray_pipe #(.VEC_W(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bin_i(bin1), .valid_i(1'b0),
    .gray_o(gray1), .gray_q_o(grayq1), .valid_q_o(vldq1), .step_o(step1));

  binary_to_gray_pipe #(.VEC_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .bin_i(bin8), .valid_i(vld8),
    .gray_o(gray8), .gray_q_o(grayq8), .valid_q_o(vldq8), .step_o(step8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one edge on dut4 and sample 1 time unit after it.
  task automatic tick4(input logic v, input logic [3:0] b);
    @(negedge clk);
    vld4 = v;
    bin4 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic cap4(input string tag, input logic [3:0] b,
                      input logic [3:0] eg, input logic es);
    tick4(1'b1, b);
    chk({tag, "_gq"}, 32'(grayq4), 32'(eg));
    chk({tag, "_vq"}, 32'(vldq4), 32'd1);
    chk({tag, "_st"}, 32'(step4), 32'(es));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    vld4 = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r8;
    rst  = 1'b1;
    vld4 = 1'b0;
    bin4 = '0;
    bin1 = 1'b0;
    bin8 = '0;
    vld8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gq", 32'(grayq4), 32'd0);
    chk("rst_vq", 32'(vldq4), 32'd0);
    chk("rst_st", 32'(step4), 32'd0);
    chk("rst_gq8", 32'(grayq8), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive combinational sweep.
    for (int i = 0; i < 16; i++) begin
      bin4 = 4'(i);
      #1;
      chk($sformatf("comb_%0d", i), 32'(gray4), 32'(gtab[i]));
    end

    // Registered latency and hold.
    do_reset();
    cap4("lat", 4'b0101, 4'b0111, 1'b0);
    tick4(1'b0, 4'b1111);
    chk("hold_gq", 32'(grayq4), 32'b0111);
    chk("hold_vq", 32'(vldq4), 32'd0);
    chk("hold_st", 32'(step4), 32'd0);

    // Step monitor from a fresh reset.
    do_reset();
    cap4("s1", 4'b0111, 4'b0100, 1'b0);
    cap4("s2", 4'b1000, 4'b1100, 1'b1);
    cap4("s3", 4'b0000, 4'b0000, 1'b0);
    cap4("s4", 4'b0011, 4'b0010, 1'b1);
    cap4("s5", 4'b0000, 4'b0000, 1'b1);
    cap4("s6", 4'b0010, 4'b0011, 1'b0);
    tick4(1'b0, 4'b0000);
    chk("idle_st", 32'(step4), 32'd0);

    // Wrap all-ones to zero, then a repeated value.
    cap4("w1", 4'b1111, 4'b1000, 1'b0);
    cap4("w2", 4'b0000, 4'b0000, 1'b1);
    cap4("same", 4'b0000, 4'b0000, 1'b0);

    // Reset mid-stream with valid asserted.
    cap4("pre", 4'b0001, 4'b0001, 1'b1);
    @(negedge clk);
    rst  = 1'b1;
    vld4 = 1'b1;
    bin4 = 4'b1010;
    #1;
    chk("rst_comb", 32'(gray4), 32'b1111);
    @(posedge clk);
    #1;
    chk("mrst_gq", 32'(grayq4), 32'd0);
    chk("mrst_vq", 32'(vldq4), 32'd0);
    chk("mrst_st", 32'(step4), 32'd0);
    chk("mrst_comb", 32'(gray4), 32'b1111);
    @(negedge clk);
    rst  = 1'b0;
    vld4 = 1'b0;
    cap4("post", 4'b0001, 4'b0001, 1'b0);

    // VEC_W = 1.
    bin1 = 1'b0;
    #1;
    chk("w1_0", 32'(gray1), 32'd0);
    bin1 = 1'b1;
    #1;
    chk("w1_1", 32'(gray1), 32'd1);

    // VEC_W = 8 directed, registered, then random.
    @(negedge clk);
    bin8 = 8'b10110100;
    vld8 = 1'b1;
    #1;
    chk("w8_comb", 32'(gray8), 32'b11101110);
    @(posedge clk);
    #1;
    chk("w8_gq", 32'(grayq8), 32'b11101110);
    chk("w8_vq", 32'(vldq8), 32'd1);
    @(negedge clk);
    vld8 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      r8   = 8'($urandom);
      bin8 = r8;
      #1;
      chk("w8_rnd", 32'(gray8), 32'(r8 ^ (r8 >> 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
